score_keeper: RTL and testbench
===============================

# score_keeper

Hit counter and 7-segment score display stage sitting directly downstream of the LT24 colour game top. It consumes the game's `score` hit flag and the `start` request, counts each new hit as one point in 4-digit packed BCD, keeps the best score across rounds, and drives four active-low HEX displays.

## Interface

**Parameters**
- `MIN_GAP`, default 1000: clock cycles after a counted hit during which further rising edges of `score` are ignored.
- `SAT_VALUE`, default 16'h9999: packed-BCD saturation ceiling for the counter. Must be a valid BCD value.

**Ports** (clock and reset first)
- `clock`, input, 1: single system clock, 50 MHz.
- `globalReset_n`, input, 1: reset, asynchronous and active-low.
- `score`, input, 1: hit flag from the game stage. Synchronous to `clock`. May stay high for many cycles.
- `clear`, input, 1: synchronous, active-high round-start pulse (game `start`).
- `show_best`, input, 1: level select. 1 shows the best score on HEX, 0 shows the current score.
- `count_bcd`, output, 16: current score in packed BCD; digit 0 is bits [3:0].
- `best_bcd`, output, 16: best score in packed BCD. Ties to 0 when the best feature is compiled out.
- `saturated`, output, 1: high while `count_bcd == SAT_VALUE`.
- `hex0`, `hex1`, `hex2`, `hex3`, output, 7 each: active-low segments in order {g,f,e,d,c,b,a}. `hex0` is the least significant digit.

## Operation

**Reset values** (all outputs and state, asynchronous on `globalReset_n` low)
- `count_bcd` = 0, `best_bcd` = 0, `saturated` = 0.
- `hex0`–`hex3` = 7'h40 (the glyph for "0").
- Edge register `score_q` = 0, gap counter = 0.

**Edge detect**
- A hit is the condition `score & ~score_q & (gap == 0)`.
- `score_q` updates every cycle, including during the gap window.

**Gap counter**
- Loads `MIN_GAP-1` on a counted hit, then decrements to 0 and holds there.
- `MIN_GAP = 0` disables the guard.

**Counter**
- Packed-BCD increment with per-digit carry: a digit of 9 wraps to 0 and carries into the next digit.
- No binary intermediate.
- At `SAT_VALUE`, a hit leaves the count unchanged. The gap counter still reloads.

**Clear**
- `count_bcd` goes to 0 and the gap counter goes to 0.
- `clear` has priority over a hit in the same cycle; that hit is dropped.

**Best score**
- On `clear`, if `count_bcd > best_bcd` (unsigned compare of packed BCD, which is numerically valid), then `best_bcd` loads `count_bcd` in the same cycle as the count is zeroed.

**Display**
- Source is `show_best ? best_bcd : count_bcd`.
- Each nibble is decoded to segments: 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10 (hex).
- Non-BCD nibbles display as 7'h7F (all segments off).

## Timing

- Hit at edge N (`score`=1 sampled with `score_q`=0): `count_bcd` and `saturated` are updated after edge N.
- `hex*` outputs are registered from the muxed source, so they reflect the new count after edge N+1.
- `show_best` change reaches `hex*` after one edge.
- `clear` at edge N: `count_bcd`=0 and the new `best_bcd` are both visible after edge N.
- `score` held high: exactly one point per rising edge, regardless of duration.
- Reset asserted mid-gap or mid-count: all state returns immediately to reset values. There is no partial update on reset release.

## Configuration

- Macro `SCORE_KEEPER_BEST_EN`.
- **Defined:** best-score register, compare and `show_best` mux are present as described.
- **Undefined:**
  - The best register is not built and `best_bcd` is tied to 16'h0000.
  - `show_best` is ignored and the display always shows `count_bcd`.
  - `clear` only zeroes the count and the gap counter.

## Test plan

- **Reset:** assert `globalReset_n`=0 mid-run → all `hex*`=7'h40, `count_bcd`=0, `saturated`=0 with no clock edge.
- **Single hit:** `MIN_GAP`=4. Hold `score` high 20 cycles → `count_bcd`=16'h0001, `hex0`=7'h79 two edges after the rise.
- **Gap guard:** `MIN_GAP`=4. Pulse `score` at cycles 0, 2 and 6 → count=2 (the cycle-2 edge is ignored).
- **Carry and saturation:** preload to 16'h0099 via hits, one more hit → 16'h0100. With `SAT_VALUE`=16'h0102, five more hits → count=16'h0102, `saturated`=1.
- **Clear vs hit and best (EN defined):** count=16'h0042, `clear` and a score edge in the same cycle → count=0, `best_bcd`=16'h0042. Then `show_best`=1 → `hex1`=7'h19, `hex0`=7'h24.
- **EN undefined:** same sequence → `best_bcd`=0 and `hex*` show count 0 regardless of `show_best`.

Source files
------------

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : score_keeper
//  Description : Hit counter for the LT24 colour game. Counts rising edges of
//                the score flag in 4-digit packed BCD, with a re-trigger
//                guard window, a saturation ceiling, an optional best-score
//                register and four registered active-low 7-segment digits.
//                Optional feature macro: SCORE_KEEPER_BEST_EN (best score
//                register, compare on clear and show_best display mux).
//  Revision    : 1.0 - initial release
// ============================================================================
module score_keeper #(
    parameter int          MIN_GAP   = 1000,
    parameter logic [15:0] SAT_VALUE = 16'h9999
) (
    input  logic        clock,
    input  logic        globalReset_n,
    input  logic        score,
    input  logic        clear,
    input  logic        show_best,
    output logic [15:0] count_bcd,
    output logic [15:0] best_bcd,
    output logic        saturated,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3
);

    // Gap counter only needs to hold MIN_GAP-1.
    localparam int             c_gap_w    = (MIN_GAP > 2) ? $clog2(MIN_GAP) : 1;
    localparam logic [c_gap_w-1:0] c_gap_load = (MIN_GAP > 0) ? c_gap_w'(MIN_GAP - 1) : '0;
    localparam logic [6:0]     c_seg_zero = 7'h40;

    // Packed-BCD +1 with per-digit carry; digit 9 wraps to 0 and carries.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic       carry;
        logic [3:0] d;
        bcd_inc = v;
        carry   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = v[4*i +: 4];
            if (carry) begin
                if (d == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = d + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    endfunction

    // Active-low {g,f,e,d,c,b,a}; non-BCD nibbles blank the digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    logic               score_q;
    logic [c_gap_w-1:0] gap_q, gap_d;
    logic [15:0]        count_q, count_d;
    logic               sat_q, sat_d;
    logic [15:0]        w_src;
    logic [3:0][6:0]    hex_q;
    logic [3:0][6:0]    w_hex_d;
    logic               w_hit;

    assign w_hit = score & ~score_q & (gap_q == '0);

    // Next-state for count, gap window and saturation flag; clear beats a hit.
    always_comb begin
        count_d = count_q;
        gap_d   = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
        if (clear) begin
            count_d = '0;
            gap_d   = '0;
        end else if (w_hit) begin
            gap_d = c_gap_load;
            if (count_q != SAT_VALUE) begin
                count_d = bcd_inc(count_q);
            end
        end
        sat_d = (count_d == SAT_VALUE);
    end

    // Edge register, gap window, count and saturation state.
    always_ff @(posedge clock or negedge globalReset_n) begin
        if (!globalReset_n) begin
            score_q <= 1'b0;
            gap_q   <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            score_q <= score;
            gap_q   <= gap_d;
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

`ifdef SCORE_KEEPER_BEST_EN
    logic [15:0] best_q, best_d;

    // Packed BCD compares correctly as unsigned binary.
    always_comb begin
        best_d = best_q;
        if (clear && (count_q > best_q)) begin
            best_d = count_q;
        end
    end

    // Best-score register, updated on the round-start clear.
    always_ff @(posedge clock or negedge globalReset_n) begin
        if (!globalReset_n) begin
            best_q <= '0;
        end else begin
            best_q <= best_d;
        end
    end

    assign best_bcd = best_q;
    assign w_src    = show_best ? best_q : count_q;
`else
    logic w_unused_show_best;

    assign w_unused_show_best = show_best;
    assign best_bcd           = 16'h0000;
    assign w_src              = count_q;
`endif

    generate
        for (genvar g = 0; g < 4; g++) begin : g_digit
            assign w_hex_d[g] = seg7(w_src[4*g +: 4]);
        end
    endgenerate

    // Registered display; reflects the selected source one edge later.
    always_ff @(posedge clock or negedge globalReset_n) begin
        if (!globalReset_n) begin
            hex_q <= {4{c_seg_zero}};
        end else begin
            hex_q <= w_hex_d;
        end
    end

    assign count_bcd = count_q;
    assign saturated = sat_q;
    assign hex0      = hex_q[0];
    assign hex1      = hex_q[1];
    assign hex2      = hex_q[2];
    assign hex3      = hex_q[3];

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_score_keeper
//  Description : Self-checking bench for score_keeper with directed scenarios
//                and a randomized run against a cycle-level behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_score_keeper;

    localparam int          MIN_GAP   = 4;
    localparam logic [15:0] SAT_VALUE = 16'h0102;
    localparam int          SAT_INT   = 102;
    localparam int          NO_HIT    = -100000;

    logic        clock;
    logic        globalReset_n;
    logic        score;
    logic        clear;
    logic        show_best;
    logic [15:0] count_bcd;
    logic [15:0] best_bcd;
    logic        saturated;
    logic [6:0]  hex0, hex1, hex2, hex3;

    int n_total;
    int n_pass;

    // Model state: plain integers, last counted-hit cycle, previous score.
    int          m_count;
    int          m_best;
    int          m_cyc;
    int          m_last;
    bit          m_sq;
    logic [27:0] m_hex;

    score_keeper #(
        .MIN_GAP   (MIN_GAP),
        .SAT_VALUE (SAT_VALUE)
    ) dut (
        .clock         (clock),
        .globalReset_n (globalReset_n),
        .score         (score),
        .clear         (clear),
        .show_best     (show_best),
        .count_bcd     (count_bcd),
        .best_bcd      (best_bcd),
        .saturated     (saturated),
        .hex0          (hex0),
        .hex1          (hex1),
        .hex2          (hex2),
        .hex3          (hex3)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        r[3:0]   = 4'(n % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[11:8]  = 4'((n / 100) % 10);
        r[15:12] = 4'((n / 1000) % 10);
        return r;
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        if (d < 4'd10) return tbl[d];
        return 7'h7F;
    endfunction

    function automatic logic [27:0] disp(input int n);
        logic [15:0] b;
        b = to_bcd(n);
        return {seg(b[15:12]), seg(b[11:8]), seg(b[7:4]), seg(b[3:0])};
    endfunction

    task automatic model_reset();
        m_count = 0;
        m_best  = 0;
        m_cyc   = 0;
        m_last  = NO_HIT;
        m_sq    = 1'b0;
        m_hex   = disp(0);
    endtask

    // One clock edge of the game rules, using pre-edge state.
    task automatic model_edge(input bit s, input bit c, input bit b);
        int shown;
        bit hit;
        shown = m_count;
`ifdef SCORE_KEEPER_BEST_EN
        if (b) shown = m_best;
`endif
        m_hex = disp(shown);
        hit   = s && !m_sq && ((m_cyc - m_last) >= MIN_GAP);
        if (c) begin
`ifdef SCORE_KEEPER_BEST_EN
            if (m_count > m_best) m_best = m_count;
`endif
            m_count = 0;
            m_last  = NO_HIT;
        end else if (hit) begin
            m_last = m_cyc;
            if (m_count < SAT_INT) m_count++;
        end
        m_sq = s;
        m_cyc++;
    endtask

    // Called at a negedge: drive inputs, take one edge, return at next negedge.
    task automatic tick(input bit s, input bit c, input bit b);
        score     = s;
        clear     = c;
        show_best = b;
        @(posedge clock);
        model_edge(s, c, b);
        @(negedge clock);
    endtask

    task automatic hit_group();
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        globalReset_n = 1'b1;
        score = 1'b0; clear = 1'b0; show_best = 1'b0;
        #2 globalReset_n = 1'b0;
        #2;
        n_total++;
        if ({hex3, hex2, hex1, hex0} !== {4{7'h40}})
            $display("FAIL reset_hex: got %h want %h", {hex3, hex2, hex1, hex0}, {4{7'h40}});
        else n_pass++;
        n_total++;
        if (count_bcd !== 16'h0000 || saturated !== 1'b0 || best_bcd !== 16'h0000)
            $display("FAIL reset_state: got count=%h sat=%b best=%h want 0/0/0", count_bcd, saturated, best_bcd);
        else n_pass++;
        @(negedge clock);
        @(negedge clock);
        globalReset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single_hit();
        tick(1'b1, 1'b0, 1'b0);
        n_total++;
        if (count_bcd !== 16'h0001 || hex0 !== 7'h40)
            $display("FAIL single_edge1: got count=%h hex0=%h want 0001/40", count_bcd, hex0);
        else n_pass++;
        tick(1'b1, 1'b0, 1'b0);
        n_total++;
        if (hex0 !== 7'h79)
            $display("FAIL single_hex0: got %h want 79", hex0);
        else n_pass++;
        for (int i = 0; i < 18; i++) tick(1'b1, 1'b0, 1'b0);
        n_total++;
        if (count_bcd !== 16'h0001)
            $display("FAIL single_held: got %h want 0001", count_bcd);
        else n_pass++;
        tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_gap_guard();
        bit pat [8];
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tick(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) tick(pat[i], 1'b0, 1'b0);
        n_total++;
        if (count_bcd !== 16'h0002 || count_bcd !== to_bcd(m_count))
            $display("FAIL gap_guard: got %h want 0002", count_bcd);
        else n_pass++;
    endtask

    task automatic test_carry_sat();
        tick(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 99; i++) hit_group();
        n_total++;
        if (count_bcd !== 16'h0099 || saturated !== 1'b0)
            $display("FAIL carry_99: got count=%h sat=%b want 0099/0", count_bcd, saturated);
        else n_pass++;
        hit_group();
        n_total++;
        if (count_bcd !== 16'h0100)
            $display("FAIL carry_100: got %h want 0100", count_bcd);
        else n_pass++;
        for (int i = 0; i < 5; i++) hit_group();
        n_total++;
        if (count_bcd !== 16'h0102 || saturated !== 1'b1)
            $display("FAIL saturate: got count=%h sat=%b want 0102/1", count_bcd, saturated);
        else n_pass++;
        n_total++;
        if ({hex3, hex2, hex1, hex0} !== {7'h40, 7'h79, 7'h40, 7'h24})
            $display("FAIL sat_hex: got %h want %h", {hex3, hex2, hex1, hex0}, {7'h40, 7'h79, 7'h40, 7'h24});
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        #3 globalReset_n = 1'b0;
        #2;
        n_total++;
        if (count_bcd !== 16'h0000 || saturated !== 1'b0 || best_bcd !== 16'h0000 ||
            {hex3, hex2, hex1, hex0} !== {4{7'h40}})
            $display("FAIL reset_midrun: got count=%h sat=%b best=%h hex=%h want 0/0/0/%h",
                     count_bcd, saturated, best_bcd, {hex3, hex2, hex1, hex0}, {4{7'h40}});
        else n_pass++;
        score = 1'b0; clear = 1'b0; show_best = 1'b0;
        @(negedge clock);
        globalReset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_clear_best();
        logic [15:0] want_best;
        logic [13:0] want_hex;
`ifdef SCORE_KEEPER_BEST_EN
        want_best = 16'h0042;
        want_hex  = {7'h19, 7'h24};
`else
        want_best = 16'h0000;
        want_hex  = {7'h40, 7'h40};
`endif
        for (int i = 0; i < 42; i++) hit_group();
        n_total++;
        if (count_bcd !== 16'h0042)
            $display("FAIL preload_42: got %h want 0042", count_bcd);
        else n_pass++;
        tick(1'b1, 1'b1, 1'b0);
        n_total++;
        if (count_bcd !== 16'h0000 || best_bcd !== want_best)
            $display("FAIL clear_vs_hit: got count=%h best=%h want 0000/%h", count_bcd, best_bcd, want_best);
        else n_pass++;
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        n_total++;
        if ({hex1, hex0} !== want_hex || {hex3, hex2} !== {7'h40, 7'h40})
            $display("FAIL show_best_hex: got %h want %h", {hex3, hex2, hex1, hex0}, {7'h40, 7'h40, want_hex});
        else n_pass++;
        tick(1'b1, 1'b0, 1'b1);
        n_total++;
        if (count_bcd !== 16'h0001)
            $display("FAIL clear_gap: got %h want 0001", count_bcd);
        else n_pass++;
    endtask

    task automatic test_random();
        bit s, c, b;
        for (int i = 0; i < 1200; i++) begin
            s = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 149) == 0);
            b = 1'($urandom_range(0, 1));
            tick(s, c, b);
            n_total++;
            if (count_bcd !== to_bcd(m_count))
                $display("FAIL rand_count cyc %0d: got %h want %h", i, count_bcd, to_bcd(m_count));
            else n_pass++;
            n_total++;
            if (best_bcd !== to_bcd(m_best) || saturated !== (m_count == SAT_INT))
                $display("FAIL rand_best_sat cyc %0d: got best=%h sat=%b want %h/%b",
                         i, best_bcd, saturated, to_bcd(m_best), (m_count == SAT_INT));
            else n_pass++;
            n_total++;
            if ({hex3, hex2, hex1, hex0} !== m_hex)
                $display("FAIL rand_hex cyc %0d: got %h want %h", i, {hex3, hex2, hex1, hex0}, m_hex);
            else n_pass++;
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        model_reset();
        test_reset();
        test_single_hit();
        test_gap_guard();
        test_carry_sat();
        test_reset_midrun();
        test_clear_best();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
